// File: rtl/battle_pkg.sv
// Shared definitions for the battle screen: state bus codes seen by the
// player-attack, enemy-attack and renderer blocks, plus default widths.
package battle_pkg;

   localparam int unsigned HP_W_DEF = 11;
   localparam int unsigned STATE_W  = 4;

   // Bus codes; ST_CHECK is internal to the sequencer and never driven on the bus.
   typedef enum logic [STATE_W-1:0] {
      ST_MENU   = 4'b0000,
      ST_PLAYER = 4'b0001,
      ST_ENEMY  = 4'b0010,
      ST_WIN    = 4'b0100,
      ST_LOSE   = 4'b0101,
      ST_GAP    = 4'b1000,
      ST_CHECK  = 4'b1001,
      ST_IDLE   = 4'b1010
   } state_e;

   // Which attack phase preceded the current gap.
   typedef enum logic {
      PH_PLAYER = 1'b0,
      PH_ENEMY  = 1'b1
   } phase_e;

   // Map an internal state onto the externally visible bus code.
   function automatic logic [STATE_W-1:0] bus_code(input state_e s);
      return (s == ST_CHECK) ? STATE_W'(ST_GAP) : STATE_W'(s);
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: one-cycle pulse, one clock after the raster reaches
// pixel (0,0). Edge detection guarantees at most one tick per frame even if
// the origin pixel spans several clocks.
//   clk, rst_n  : clock, async active-low reset
//   hcount_i    : current pixel column
//   vcount_i    : current pixel row
//   tick_o      : registered frame-start pulse
module frame_tick_gen #(
   parameter int unsigned HC_W = 11,
   parameter int unsigned VC_W = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [HC_W-1:0] hcount_i,
   input  logic [VC_W-1:0] vcount_i,
   output logic            tick_o
);

   logic origin_c;
   logic origin_q;
   logic tick_q;

   assign origin_c = (hcount_i == '0) && (vcount_i == '0);

   // Rising edge of the origin condition, registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         origin_q <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         origin_q <= origin_c;
         tick_q   <= origin_c & ~origin_q;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/battle_sequencer.sv
// Battle turn scheduler: drives the shared state bus through
// MENU -> PLAYER -> GAP -> ENEMY -> GAP -> MENU, resolves win/lose from the
// health inputs, counts rounds and force-ends phases that overrun.
//   clk, rst                 : clock, async active-low reset
//   hcount_in, vcount_in     : raster position (frame tick source)
//   start_in, confirm_in     : start/restart and menu attack selection
//   player_*/enemy_* busy/fin: attack block handshakes (finished is held)
//   enemy_hp_in, player_hp_in: health, sampled in the check cycle
//   state_out                : state bus code
//   round_out                : completed rounds, saturating
//   new_game_out             : one-cycle pulse on game (re)start
//   timeout_out              : sticky, a phase was force-ended
module battle_sequencer
   import battle_pkg::*;
#(
   parameter int unsigned GAP_FRAMES     = 30,
   parameter int unsigned TIMEOUT_FRAMES = 600,
   parameter int unsigned HP_W           = HP_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [10:0]     hcount_in,
   input  logic [9:0]      vcount_in,
   input  logic            start_in,
   input  logic            confirm_in,
   input  logic            player_busy_in,
   input  logic            player_finished_in,
   input  logic            enemy_busy_in,
   input  logic            enemy_finished_in,
   input  logic [HP_W-1:0] enemy_hp_in,
   input  logic [HP_W-1:0] player_hp_in,
   output logic [3:0]      state_out,
   output logic [7:0]      round_out,
   output logic            new_game_out,
   output logic            timeout_out
);

   localparam int unsigned PH_CNT_W  = 10;
   localparam int unsigned GAP_CNT_W = 6;
   localparam logic [PH_CNT_W-1:0]  PH_LAST  = PH_CNT_W'(TIMEOUT_FRAMES - 1);
   localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_FRAMES - 1);

   state_e               state_q, state_d;
   phase_e               last_q, last_d;
   logic [PH_CNT_W-1:0]  phase_cnt_q, phase_cnt_d;
   logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
   logic                 entry_q, entry_d;
   logic [7:0]           round_q, round_d;
   logic                 new_game_q, new_game_d;
   logic                 timeout_q, timeout_d;
   logic [3:0]           state_out_q;
   logic                 tick;
   logic                 fin_c;
   logic                 unused_busy_c;

   // Busy lines are diagnostic only; progress depends on finished alone.
   assign unused_busy_c = player_busy_in | enemy_busy_in;

   frame_tick_gen #(.HC_W(11), .VC_W(10)) u_tick (
      .clk      (clk),
      .rst_n    (rst),
      .hcount_i (hcount_in),
      .vcount_i (vcount_in),
      .tick_o   (tick)
   );

   assign fin_c = (state_q == ST_PLAYER) ? player_finished_in : enemy_finished_in;

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         last_q      <= PH_PLAYER;
         phase_cnt_q <= '0;
         gap_cnt_q   <= '0;
         entry_q     <= 1'b0;
         round_q     <= '0;
         new_game_q  <= 1'b0;
         timeout_q   <= 1'b0;
         state_out_q <= 4'b1010;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         phase_cnt_q <= phase_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         entry_q     <= entry_d;
         round_q     <= round_d;
         new_game_q  <= new_game_d;
         timeout_q   <= timeout_d;
         state_out_q <= bus_code(state_d);
      end
   end

   // Next-state logic.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      phase_cnt_d = phase_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      entry_d     = 1'b0;
      round_d     = round_q;
      new_game_d  = 1'b0;
      timeout_d   = timeout_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_in) begin
               state_d    = ST_MENU;
               new_game_d = 1'b1;
               round_d    = '0;
               timeout_d  = 1'b0;
            end
         end
         ST_MENU: begin
            if (confirm_in) begin
               state_d     = ST_PLAYER;
               phase_cnt_d = '0;
               entry_d     = 1'b1;
            end
         end
         ST_PLAYER, ST_ENEMY: begin
            if (tick) phase_cnt_d = phase_cnt_q + 1'b1;
            // Finished may still be held from before entry, so skip the first cycle.
            if (!entry_q && fin_c) begin
               state_d   = ST_GAP;
               gap_cnt_d = '0;
               last_d    = (state_q == ST_PLAYER) ? PH_PLAYER : PH_ENEMY;
            end else if (tick && (phase_cnt_q == PH_LAST)) begin
               state_d   = ST_GAP;
               gap_cnt_d = '0;
               last_d    = (state_q == ST_PLAYER) ? PH_PLAYER : PH_ENEMY;
               timeout_d = 1'b1;
            end
         end
         ST_GAP: begin
            if (tick) begin
               gap_cnt_d = gap_cnt_q + 1'b1;
               if (gap_cnt_q == GAP_LAST) state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (enemy_hp_in == '0) begin
               state_d = ST_WIN;
            end else if (player_hp_in == '0) begin
               state_d = ST_LOSE;
            end else if (last_q == PH_PLAYER) begin
               state_d     = ST_ENEMY;
               phase_cnt_d = '0;
               entry_d     = 1'b1;
            end else begin
               state_d = ST_MENU;
               if (round_q != 8'hFF) round_d = round_q + 8'd1;
            end
         end
         ST_WIN, ST_LOSE: begin
            if (start_in) begin
               state_d    = ST_MENU;
               new_game_d = 1'b1;
               round_d    = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign state_out    = state_out_q;
   assign round_out    = round_q;
   assign new_game_out = new_game_q;
   assign timeout_out  = timeout_q;

endmodule

// File: tb/tb_battle_sequencer.sv
// Scoreboard bench for battle_sequencer: stimulus pushes the expected bus
// transitions, a negedge monitor pops and compares on every state_out change.
module tb_battle_sequencer;

   localparam int F = 8;  // clocks per synthetic frame

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [10:0] hcount = 11'd5;
   logic [9:0]  vcount = 10'd3;
   logic        start = 1'b0, confirm = 1'b0;
   logic        p_busy = 1'b0, p_fin = 1'b0, e_busy = 1'b0, e_fin = 1'b0;
   logic [10:0] enemy_hp = 11'd100, player_hp = 11'd100;
   logic [3:0]  state_out;
   logic [7:0]  round_out;
   logic        new_game_out, timeout_out;

   always #5 clk = ~clk;

   battle_sequencer dut (
      .clk                (clk),
      .rst                (rst),
      .hcount_in          (hcount),
      .vcount_in          (vcount),
      .start_in           (start),
      .confirm_in         (confirm),
      .player_busy_in     (p_busy),
      .player_finished_in (p_fin),
      .enemy_busy_in      (e_busy),
      .enemy_finished_in  (e_fin),
      .enemy_hp_in        (enemy_hp),
      .player_hp_in       (player_hp),
      .state_out          (state_out),
      .round_out          (round_out),
      .new_game_out       (new_game_out),
      .timeout_out        (timeout_out)
   );

   typedef struct {
      logic [3:0] st;
      int         rnd;
      logic       to;
      logic       ng;
      int         dwell;  // frames spent in the state being left; -1 = don't care
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   // Raster: origin pixel on one clock out of every F.
   int cyc = 0;
   always @(negedge clk) begin
      cyc++;
      if (cyc % F == 0) begin
         hcount = 11'd0;
         vcount = 10'd0;
      end else begin
         hcount = 11'((cyc % F) * 7);
         vcount = 10'd3;
      end
   end

   // Frame starts as seen by the DUT at each rising edge.
   int fs = 0;
   always @(posedge clk) if (hcount == 11'd0 && vcount == 10'd0) fs <= fs + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   // Monitor.
   bit         mon_en = 1'b0;
   logic [3:0] prev_st = 4'b1010;
   int         fs_prev = 0, fs_mark = 0;
   exp_t       mon_e;
   always @(negedge clk) begin
      if (mon_en) begin
         if (state_out !== prev_st) begin
            if (sb.size() == 0) begin
               chk("unexpected_transition", int'(state_out), int'(prev_st));
            end else begin
               mon_e = sb.pop_front();
               chk("state", int'(state_out), int'(mon_e.st));
               chk("round", int'(round_out), mon_e.rnd);
               chk("timeout", int'(timeout_out), int'(mon_e.to));
               chk("new_game", int'(new_game_out), int'(mon_e.ng));
               if (mon_e.dwell >= 0) chk("dwell_frames", fs_prev - fs_mark, mon_e.dwell);
            end
            fs_mark = fs_prev;
            prev_st = state_out;
         end else if (new_game_out !== 1'b0) begin
            chk("new_game_width", int'(new_game_out), 0);
         end
         fs_prev = fs;
      end
   end

   task automatic push(input logic [3:0] st, input int rnd, input logic to,
                       input logic ng, input int dw);
      exp_t x;
      x.st = st; x.rnd = rnd; x.to = to; x.ng = ng; x.dwell = dw;
      sb.push_back(x);
   endtask

   task automatic wait_bus(input logic [3:0] code, input int budget, input string name);
      int n = 0;
      while (state_out !== code && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (state_out !== code) chk(name, int'(state_out), int'(code));
   endtask

   task automatic start_pulse();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   // Returns at the negedge just after PLAYER entry; base = frame count before entry.
   task automatic confirm_pulse(input logic with_start, output int base);
      @(negedge clk);
      base    = fs;
      confirm = 1'b1;
      start   = with_start;
      @(negedge clk);
      confirm = 1'b0;
      start   = 1'b0;
   endtask

   // Finished pulsed on the phase entry cycle only; must be ignored.
   task automatic entry_pulse(input bit enemy);
      if (enemy) e_fin = 1'b1; else p_fin = 1'b1;
      @(negedge clk);
      e_fin = 1'b0;
      p_fin = 1'b0;
   endtask

   // Raise finished once 'frames' ticks have occurred in the phase; hold until GAP.
   task automatic finish_at(input bit enemy, input int base, input int frames);
      int n = 0;
      while ((fs - base) < frames && n < (frames + 4) * F) begin
         @(negedge clk);
         n++;
      end
      if ((fs - base) < frames) chk("finish_wait", fs - base, frames);
      if (enemy) e_fin = 1'b1; else p_fin = 1'b1;
      wait_bus(4'b1000, 10, "wait_gap_after_finish");
      e_fin = 1'b0;
      p_fin = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int b;
      repeat (3) @(negedge clk);
      chk("reset_state", int'(state_out), 'ha);
      chk("reset_round", int'(round_out), 0);
      chk("reset_new_game", int'(new_game_out), 0);
      chk("reset_timeout", int'(timeout_out), 0);
      #2 rst = 1'b1;
      fs_prev = fs;
      fs_mark = fs;
      mon_en  = 1'b1;

      // Start from IDLE.
      push(4'b0000, 0, 0, 1, -1);
      start_pulse();
      wait_bus(4'b0000, 10, "wait_menu_start");

      // Normal round with entry-cycle finished pulses ignored.
      push(4'b0001, 0, 0, 0, -1);
      confirm_pulse(1'b0, b);
      entry_pulse(1'b0);
      push(4'b1000, 0, 0, 0, 20);
      push(4'b0010, 0, 0, 0, 30);
      finish_at(1'b0, b, 20);
      wait_bus(4'b0010, 40 * F, "wait_enemy_r1");
      b = fs;
      entry_pulse(1'b1);
      push(4'b1000, 0, 0, 0, 5);
      push(4'b0000, 1, 0, 0, 30);
      finish_at(1'b1, b, 5);
      wait_bus(4'b0000, 40 * F, "wait_menu_r1");

      // Enemy killed during the player phase.
      enemy_hp = 11'd0;
      push(4'b0001, 1, 0, 0, -1);
      confirm_pulse(1'b0, b);
      push(4'b1000, 1, 0, 0, 3);
      push(4'b0100, 1, 0, 0, 30);
      finish_at(1'b0, b, 3);
      wait_bus(4'b0100, 40 * F, "wait_win_kill");
      enemy_hp = 11'd100;
      push(4'b0000, 0, 0, 1, -1);
      start_pulse();
      wait_bus(4'b0000, 10, "wait_menu_restart1");

      // Both healths zero resolves to WIN.
      enemy_hp  = 11'd0;
      player_hp = 11'd0;
      push(4'b0001, 0, 0, 0, -1);
      confirm_pulse(1'b0, b);
      push(4'b1000, 0, 0, 0, 2);
      push(4'b0100, 0, 0, 0, 30);
      finish_at(1'b0, b, 2);
      wait_bus(4'b0100, 40 * F, "wait_win_both");
      enemy_hp  = 11'd100;
      player_hp = 11'd100;
      push(4'b0000, 0, 0, 1, -1);
      start_pulse();
      wait_bus(4'b0000, 10, "wait_menu_restart2");

      // start and confirm together in MENU: confirm wins; then player dies after ENEMY.
      push(4'b0001, 0, 0, 0, -1);
      confirm_pulse(1'b1, b);
      push(4'b1000, 0, 0, 0, 2);
      push(4'b0010, 0, 0, 0, 30);
      finish_at(1'b0, b, 2);
      wait_bus(4'b0010, 40 * F, "wait_enemy_lose");
      b = fs;
      player_hp = 11'd0;
      push(4'b1000, 0, 0, 0, 4);
      push(4'b0101, 0, 0, 0, 30);
      finish_at(1'b1, b, 4);
      wait_bus(4'b0101, 40 * F, "wait_lose");
      player_hp = 11'd100;
      push(4'b0000, 0, 0, 1, -1);
      start_pulse();
      wait_bus(4'b0000, 10, "wait_menu_restart3");

      // Player phase times out; timeout_out is sticky through the round.
      push(4'b0001, 0, 0, 0, -1);
      confirm_pulse(1'b0, b);
      push(4'b1000, 0, 1, 0, 600);
      push(4'b0010, 0, 1, 0, 30);
      wait_bus(4'b1000, 604 * F, "wait_gap_timeout");
      wait_bus(4'b0010, 40 * F, "wait_enemy_timeout");
      b = fs;
      push(4'b1000, 0, 1, 0, 1);
      push(4'b0000, 1, 1, 0, 30);
      finish_at(1'b1, b, 1);
      wait_bus(4'b0000, 40 * F, "wait_menu_timeout");

      // Asynchronous reset in the middle of a gap.
      push(4'b0001, 1, 1, 0, -1);
      confirm_pulse(1'b0, b);
      push(4'b1000, 1, 1, 0, 1);
      finish_at(1'b0, b, 1);
      repeat (3 * F) @(negedge clk);
      push(4'b1010, 0, 0, 0, -1);
      #2 rst = 1'b0;
      #1;
      chk("async_reset_state", int'(state_out), 'ha);
      chk("async_reset_round", int'(round_out), 0);
      chk("async_reset_timeout", int'(timeout_out), 0);
      @(negedge clk);
      #2 rst = 1'b1;
      push(4'b0000, 0, 0, 1, -1);
      start_pulse();
      wait_bus(4'b0000, 10, "wait_menu_after_reset");

      // Finished coincident with the timeout tick: finished wins.
      push(4'b0001, 0, 0, 0, -1);
      confirm_pulse(1'b0, b);
      push(4'b1000, 0, 0, 0, 600);
      push(4'b0010, 0, 0, 0, 30);
      finish_at(1'b0, b, 600);
      wait_bus(4'b0010, 40 * F, "wait_enemy_coincident");
      b = fs;
      push(4'b1000, 0, 0, 0, 1);
      push(4'b0000, 1, 0, 0, 30);
      finish_at(1'b1, b, 1);
      wait_bus(4'b0000, 40 * F, "wait_menu_coincident");

      repeat (4) @(negedge clk);
      if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/battle_sequencer.md
Name: battle_sequencer

Overview:
- Top-level turn scheduler for the battle screen: drives the shared 4-bit state bus consumed by the player-attack block and the enemy-attack block.
- Sequences MENU -> PLAYER -> GAP -> ENEMY -> GAP -> MENU using each block's busy/finished handshake.
- Checks health for win/lose, counts rounds, and applies a frame-based watchdog.

Parameters:
- GAP_FRAMES, 30, frames of inter-phase pause (state bus = GAP code).
- TIMEOUT_FRAMES, 600, maximum frames a PLAYER/ENEMY phase may last before a forced exit.
- HP_W, 11, width of the health inputs.

Ports:
- clk  input  1  system/pixel clock.
- rst  input  1  reset, asynchronous, active-low (asserted at 0).
- hcount_in  input  11  current pixel column.
- vcount_in  input  10  current pixel row.
- start_in  input  1  start/restart request (level; acted on when high).
- confirm_in  input  1  menu "attack" selection.
- player_busy_in  input  1  busy from the player-attack block.
- player_finished_in  input  1  finished from the player-attack block; held high until the state bus leaves 4'b0001.
- enemy_busy_in  input  1  busy from the enemy-attack block.
- enemy_finished_in  input  1  finished from the enemy-attack block; same held-level rule for 4'b0010.
- enemy_hp_in  input  HP_W  enemy health.
- player_hp_in  input  HP_W  player health.
- state_out  output  4  state bus code.
- round_out  output  8  completed rounds; saturates at 255.
- new_game_out  output  1  one-cycle pulse on game (re)start.
- timeout_out  output  1  sticky flag: a phase was force-ended.

Behaviour:
- State codes on state_out:
  - IDLE 4'b1010, MENU 4'b0000, PLAYER 4'b0001, ENEMY 4'b0010.
  - WIN 4'b0100, LOSE 4'b0101, GAP 4'b1000.
  - CHECK is internal: one cycle, state_out shows GAP.
- Reset (rst=0, asynchronous): state IDLE, state_out=4'b1010, round_out=0, new_game_out=0, timeout_out=0, all counters 0, last_phase=PLAYER. The same values apply if reset occurs mid-phase.
- Frame tick: registered edge of (hcount_in==0 && vcount_in==0), so at most one tick per frame. The tick is 1 cycle after the condition.
- Transitions (registered; state_out changes the cycle after the cause):
  - IDLE: start_in -> MENU; new_game_out pulses for 1 cycle; round_out and timeout_out clear.
  - MENU: confirm_in -> PLAYER. If start_in and confirm_in are high together, confirm_in wins.
  - PLAYER:
    - finished_in is ignored on the entry cycle.
    - player_finished_in=1 -> GAP, last_phase=PLAYER.
    - Phase frame counter reaching TIMEOUT_FRAMES -> GAP and timeout_out<=1.
    - If finished_in and timeout occur in the same cycle, finished wins and timeout_out is unchanged.
  - ENEMY: identical to PLAYER, using the enemy_* inputs; sets last_phase=ENEMY.
  - GAP: counts frame ticks; at GAP_FRAMES ticks -> CHECK.
  - CHECK, in priority order:
    - enemy_hp_in==0 -> WIN (this also covers both healths at zero).
    - else player_hp_in==0 -> LOSE.
    - else last_phase==PLAYER -> ENEMY.
    - else round_out++ (saturating) -> MENU.
  - WIN/LOSE: hold; start_in -> MENU with new_game_out pulse and round_out cleared.
- Busy inputs are not required for progress. busy_in is used only for diagnostics, and finished_in alone ends a phase.
- Counters:
  - Phase frame counter: 10 bits, cleared on every phase entry.
  - Gap frame counter: 6 bits minimum, cleared on GAP entry.
  - Both compare with ==.
- The health comparisons are purely combinational on the inputs, sampled in the CHECK cycle.

Decomposition:
- Package battle_pkg: a 4-bit state enum with the codes above, shared by the player, enemy and renderer blocks; also the HP_W default.
- One natural sub-module, frame_tick_gen: hcount/vcount -> one-cycle tick. It is reusable by the attack blocks.

Test Plan:
- Reset then start_in=1 for 1 cycle -> state_out 1010 -> 0000, new_game_out high exactly 1 cycle, round_out=0.
- Normal round:
  - confirm_in; player_finished_in rises at frame 20, held until the bus changes.
  - Required: 0001 -> 1000 for 30 ticks -> 0010.
  - Then enemy_finished_in -> 1000 for 30 ticks -> 0000, round_out=1.
  - Required: finished_in on the entry cycle is ignored.
- Kill: enemy_hp_in=0 while PLAYER ends -> after the gap, state_out=0100. With both healths 0 -> 0100. With player_hp_in=0 only, after ENEMY -> 0101.
- Timeout: PLAYER with finished never asserted -> 1000 after exactly 600 ticks and timeout_out=1 (sticky). Finished coincident with tick 600 -> timeout_out stays 0.
- Reset mid-GAP (rst low for 1 cycle, asynchronously) -> state_out=1010 immediately, counters cleared; a later start_in restarts cleanly.
- WIN then start_in -> 0000, round_out=0, new_game_out pulse. start_in and confirm_in together in MENU -> 0001.
